// File: rtl/video_pattern_checker_pkg.sv
// Shared constants for the video pattern checker: pattern IDs, FSM states and
// default 640x480 active geometry.
package video_pattern_checker_pkg;

  localparam logic [3:0] PAT_OFF     = 4'd0;
  localparam logic [3:0] PAT_RED     = 4'd1;
  localparam logic [3:0] PAT_GRN     = 4'd2;
  localparam logic [3:0] PAT_BLU     = 4'd3;
  localparam logic [3:0] PAT_CHECKER = 4'd4;
  localparam logic [3:0] PAT_BARS    = 4'd5;
  localparam logic [3:0] PAT_BORDER  = 4'd6;

  localparam logic [1:0] ST_SEEK  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEF_COLS = 640;
  localparam int DEF_ROWS = 480;
  localparam int POS_W    = 10;

endpackage

// File: rtl/video_pattern_checker_sync.sv
// Sync edge detection and col/row reconstruction for the pattern checker,
// plus line/frame geometry fault flags.
module video_sync_to_pos
  import video_pattern_checker_pkg::*;
#(
  parameter int ACTIVE_COLS = DEF_COLS,
  parameter int ACTIVE_ROWS = DEF_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  output logic [POS_W-1:0] col,
  output logic [POS_W-1:0] row,
  output logic             v_rise,
  output logic             v_fall,
  output logic             col_bad,
  output logic             row_bad
);

  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic             h_prev;
  logic             v_prev;
  logic             h_rise;
  logic             h_fall;
  logic [POS_W-1:0] col_cnt;
  logic [POS_W-1:0] row_cnt;

  assign h_rise  = hsync & ~h_prev;
  assign h_fall  = ~hsync & h_prev;
  assign v_rise  = vsync & ~v_prev;
  assign v_fall  = ~vsync & v_prev;
  assign col     = h_rise ? '0 : col_cnt;
  assign row     = v_rise ? '0 : row_cnt;
  assign col_bad = h_fall && (col_cnt != POS_W'(ACTIVE_COLS));
  assign row_bad = v_fall && (row_cnt != POS_W'(ACTIVE_ROWS));

  // Previous-sync registers reset high so a release in the middle of a frame
  // never looks like a fresh VSync rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_prev  <= 1'b1;
      v_prev  <= 1'b1;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      h_prev <= hsync;
      v_prev <= vsync;
      if (h_rise)
        col_cnt <= POS_W'(1);
      else if (hsync && (col_cnt != POS_MAX))
        col_cnt <= col_cnt + 1'b1;
      if (v_rise)
        row_cnt <= '0;
      else if (h_fall && vsync && (row_cnt != POS_MAX))
        row_cnt <= row_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_pattern_checker.sv
// Receive-side test pattern checker: rebuilds pixel position from syncs, recomputes
// the expected pattern and counts per-frame mismatches with geometry checking.
module video_pattern_checker
  import video_pattern_checker_pkg::*;
#(
  parameter int VIDEO_WIDTH = 3,
  parameter int ACTIVE_COLS = DEF_COLS,
  parameter int ACTIVE_ROWS = DEF_ROWS,
  parameter int ERR_WIDTH   = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [3:0]             i_Pattern,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_Locked,
  output logic                   o_Frame_Done,
  output logic                   o_Frame_Pass,
  output logic [ERR_WIDTH-1:0]   o_Err_Count,
  output logic                   o_Sync_Err
);

  localparam int PIX_W = 3 * VIDEO_WIDTH;
  localparam int BAR_W = ACTIVE_COLS / 8;

  logic [1:0]       rst_sync;
  logic             rst_int;
  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row;
  logic             v_rise;
  logic             v_fall;
  logic             col_bad;
  logic             row_bad;
  logic [1:0]       state;
  logic [3:0]       pat_q;
  logic [ERR_WIDTH-1:0] err_cnt;
  logic [PIX_W-1:0] exp_px;
  logic [PIX_W-1:0] rx_px;
  logic             px_bad;

  function automatic logic [PIX_W-1:0] expected_pixel(input logic [3:0] pat,
                                                       input logic [POS_W-1:0] c,
                                                       input logic [POS_W-1:0] r);
    logic       red, grn, blu, on;
    logic [2:0] bar;
    red = 1'b0;
    grn = 1'b0;
    blu = 1'b0;
    on  = 1'b0;
    bar = 3'(c / POS_W'(BAR_W));
    case (pat)
      PAT_RED: red = 1'b1;
      PAT_GRN: grn = 1'b1;
      PAT_BLU: blu = 1'b1;
      PAT_CHECKER: on = c[5] ^ r[5];
      PAT_BARS: begin
        red = bar[2];
        grn = bar[1];
        blu = bar[0];
      end
      PAT_BORDER: on = (r <= POS_W'(1)) || (r >= POS_W'(ACTIVE_ROWS - 2)) ||
                       (c <= POS_W'(1)) || (c >= POS_W'(ACTIVE_COLS - 2));
      default: ;
    endcase
    if (on) begin
      red = 1'b1;
      grn = 1'b1;
      blu = 1'b1;
    end
    return {{VIDEO_WIDTH{red}}, {VIDEO_WIDTH{grn}}, {VIDEO_WIDTH{blu}}};
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Reset asserts at once but is released two clocks after i_Rst drops.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  video_sync_to_pos #(
    .ACTIVE_COLS(ACTIVE_COLS),
    .ACTIVE_ROWS(ACTIVE_ROWS)
  ) u_pos (
    .clk    (i_Clk),
    .rst    (rst_int),
    .hsync  (i_HSync),
    .vsync  (i_VSync),
    .col    (col),
    .row    (row),
    .v_rise (v_rise),
    .v_fall (v_fall),
    .col_bad(col_bad),
    .row_bad(row_bad)
  );

  assign exp_px = expected_pixel(pat_q, col, row);
  assign rx_px  = {i_Red_Video, i_Grn_Video, i_Blu_Video};
  assign px_bad = i_HSync && i_VSync && (rx_px != exp_px);

  always_ff @(posedge i_Clk or posedge rst_int) begin
    if (rst_int) begin
      state        <= ST_SEEK;
      pat_q        <= '0;
      err_cnt      <= '0;
      o_Locked     <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Frame_Pass <= 1'b0;
      o_Err_Count  <= '0;
      o_Sync_Err   <= 1'b0;
    end else begin
      o_Frame_Done <= 1'b0;
      o_Sync_Err   <= 1'b0;
      case (state)
        ST_SEEK: begin
          if (v_rise) begin
            pat_q   <= i_Pattern;
            err_cnt <= '0;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (col_bad || row_bad) begin
            o_Sync_Err   <= 1'b1;
            o_Locked     <= 1'b0;
            o_Frame_Pass <= 1'b0;
            state        <= ST_SEEK;
          end else if (v_fall) begin
            state <= ST_DONE;
          end else if (px_bad) begin
            err_cnt <= sat_inc(err_cnt);
          end
        end
        ST_DONE: begin
          o_Frame_Done <= 1'b1;
          o_Err_Count  <= err_cnt;
          o_Frame_Pass <= (err_cnt == '0);
          o_Locked     <= 1'b1;
          state        <= ST_SEEK;
        end
        default: state <= ST_SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_video_pattern_checker.sv
// Directed bench for video_pattern_checker on a reduced 64x48 raster with an
// 8-bit error counter so saturation and multi-frame scenarios stay short.
module tb_video_pattern_checker;

  localparam int VW     = 3;
  localparam int COLS   = 64;
  localparam int ROWS   = 48;
  localparam int EW     = 8;
  localparam int HBLANK = 8;
  localparam int LINE   = COLS + HBLANK;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    pattern;
  logic          hsync;
  logic          vsync;
  logic [VW-1:0] red;
  logic [VW-1:0] grn;
  logic [VW-1:0] blu;
  logic          locked;
  logic          done;
  logic          pass;
  logic [EW-1:0] err;
  logic          sync_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int sync_cnt    = 0;
  int done_cyc    = 0;
  int vfall_cyc   = 0;
  logic          snap_locked, snap_pass, snap_done;
  logic [EW-1:0] snap_err;

  video_pattern_checker #(
    .VIDEO_WIDTH(VW),
    .ACTIVE_COLS(COLS),
    .ACTIVE_ROWS(ROWS),
    .ERR_WIDTH  (EW)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Pattern   (pattern),
    .i_HSync     (hsync),
    .i_VSync     (vsync),
    .i_Red_Video (red),
    .i_Grn_Video (grn),
    .i_Blu_Video (blu),
    .o_Locked    (locked),
    .o_Frame_Done(done),
    .o_Frame_Pass(pass),
    .o_Err_Count (err),
    .o_Sync_Err  (sync_err)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sync_err) sync_cnt++;
  end

  // Reference generator: what a correct pattern source would transmit.
  function automatic logic [8:0] gen_pixel(input int p, input int c, input int r);
    logic rr, gg, bb;
    logic [2:0] bar;
    rr = 1'b0; gg = 1'b0; bb = 1'b0;
    bar = 3'(c / (COLS / 8));
    case (p)
      1: rr = 1'b1;
      2: gg = 1'b1;
      3: bb = 1'b1;
      4: begin rr = (((c >> 5) & 1) != ((r >> 5) & 1)); gg = rr; bb = rr; end
      5: begin rr = bar[2]; gg = bar[1]; bb = bar[0]; end
      6: begin rr = (r <= 1) || (r >= ROWS - 2) || (c <= 1) || (c >= COLS - 2); gg = rr; bb = rr; end
      default: ;
    endcase
    return {{3{rr}}, {3{gg}}, {3{bb}}};
  endfunction

  // mode 0 clean, 1 two corrupted pixels, 2 every red channel inverted.
  task automatic drive_frame(input int ps, input int sel0, input int sel1, input int mode,
                             input int short_row, input int rst_row);
    logic [8:0] px;
    int ncols;
    pattern = 4'(sel0);
    vsync = 1'b1;
    hsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < ROWS; r++) begin
      if (r == ROWS / 2) pattern = 4'(sel1);
      if (r == rst_row) begin
        rst = 1'b1;
        #1;
        snap_locked = locked;
        snap_pass   = pass;
        snap_done   = done;
        snap_err    = err;
        @(negedge clk);
        rst = 1'b0;
      end
      ncols = (r == short_row) ? COLS - 1 : COLS;
      for (int c = 0; c < ncols; c++) begin
        hsync = 1'b1;
        px = gen_pixel(ps, c, r);
        if (mode == 1 && c == 40 && r == 10) px[8:6] = 3'd0;
        if (mode == 1 && c == COLS - 1 && r == ROWS - 1) px[2:0] = 3'd5;
        if (mode == 2) px[8:6] = ~px[8:6];
        {red, grn, blu} = px;
        @(negedge clk);
      end
      hsync = 1'b0;
      {red, grn, blu} = '0;
      repeat (HBLANK) @(negedge clk);
    end
    vsync = 1'b0;
    vfall_cyc = cyc;
    repeat (LINE) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pattern = '0; hsync = 1'b0; vsync = 1'b0;
    red = '0; grn = '0; blu = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %0b want 0", locked); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass got %0b want 0", pass); end
    vectors++; if (err !== 8'h00) begin miscompares++; $display("FAIL reset_err got %0h want 0", err); end
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_sync_err got %0b want 0", sync_err); end
  endtask

  task automatic test_bars_clean();
    int d0, s0;
    d0 = done_cnt; s0 = sync_cnt;
    drive_frame(5, 5, 5, 0, -1, -1);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL bars_done_count got %0d want 1", done_cnt - d0); end
    vectors++; if (err !== 8'h00) begin miscompares++; $display("FAIL bars_err got %0h want 0", err); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL bars_pass got %0b want 1", pass); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL bars_locked got %0b want 1", locked); end
    vectors++; if (done_cyc - vfall_cyc !== 2) begin miscompares++; $display("FAIL bars_latency got %0d want 2", done_cyc - vfall_cyc); end
    vectors++; if (sync_cnt - s0 !== 0) begin miscompares++; $display("FAIL bars_sync_err got %0d want 0", sync_cnt - s0); end
  endtask

  task automatic test_checker_errors();
    int d0;
    d0 = done_cnt;
    drive_frame(4, 4, 4, 1, -1, -1);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL checker_done got %0d want 1", done_cnt - d0); end
    vectors++; if (err !== 8'd2) begin miscompares++; $display("FAIL checker_err got %0d want 2", err); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL checker_pass got %0b want 0", pass); end
  endtask

  task automatic test_saturation();
    drive_frame(1, 1, 1, 2, -1, -1);
    vectors++; if (err !== 8'hFF) begin miscompares++; $display("FAIL sat_err got %0h want ff", err); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL sat_pass got %0b want 0", pass); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL sat_locked got %0b want 1", locked); end
  endtask

  task automatic test_border();
    int d0;
    d0 = done_cnt;
    drive_frame(6, 6, 6, 0, -1, -1);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL border_done got %0d want 1", done_cnt - d0); end
    vectors++; if (err !== 8'h00) begin miscompares++; $display("FAIL border_err got %0h want 0", err); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL border_pass got %0b want 1", pass); end
  endtask

  task automatic test_geometry_fault();
    int d0, s0;
    d0 = done_cnt; s0 = sync_cnt;
    drive_frame(5, 5, 5, 0, 10, -1);
    vectors++; if (sync_cnt - s0 !== 1) begin miscompares++; $display("FAIL geom_sync_err got %0d want 1", sync_cnt - s0); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL geom_done got %0d want 0", done_cnt - d0); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL geom_locked got %0b want 0", locked); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL geom_pass got %0b want 0", pass); end
    d0 = done_cnt;
    drive_frame(5, 5, 5, 0, -1, -1);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL recover_done got %0d want 1", done_cnt - d0); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL recover_pass got %0b want 1", pass); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL recover_locked got %0b want 1", locked); end
    vectors++; if (err !== 8'h00) begin miscompares++; $display("FAIL recover_err got %0h want 0", err); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    drive_frame(2, 2, 3, 0, -1, -1);
    vectors++; if (err !== 8'h00) begin miscompares++; $display("FAIL patchg_a_err got %0h want 0", err); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL patchg_a_pass got %0b want 1", pass); end
    drive_frame(3, 3, 3, 0, -1, -1);
    vectors++; if (err !== 8'h00) begin miscompares++; $display("FAIL patchg_b_err got %0h want 0", err); end
    vectors++; if (done_cnt - d0 !== 2) begin miscompares++; $display("FAIL patchg_done got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt;
    drive_frame(5, 5, 5, 0, -1, 20);
    vectors++; if (snap_locked !== 1'b0) begin miscompares++; $display("FAIL midrst_locked got %0b want 0", snap_locked); end
    vectors++; if (snap_pass !== 1'b0) begin miscompares++; $display("FAIL midrst_pass got %0b want 0", snap_pass); end
    vectors++; if (snap_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %0b want 0", snap_done); end
    vectors++; if (snap_err !== 8'h00) begin miscompares++; $display("FAIL midrst_err got %0h want 0", snap_err); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL midrst_partial_done got %0d want 0", done_cnt - d0); end
    d0 = done_cnt;
    drive_frame(5, 5, 5, 0, -1, -1);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL midrst_next_done got %0d want 1", done_cnt - d0); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL midrst_next_pass got %0b want 1", pass); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL midrst_next_locked got %0b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_bars_clean();
    test_checker_errors();
    test_saturation();
    test_border();
    test_geometry_fault();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
